// File: rtl/ula_muldiv_seq.sv
// Multi-cycle HI/LO multiply/divide sequencer.
// Runs a WIDTH-step shift-add multiply or restoring divide on operand
// magnitudes, then applies the latched signs and writes HI/LO in one cycle.
// busy stalls dependent instructions; mthi/mtlo are serviced while idle.
module ula_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1101;

  // Counter must be able to represent WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             is_mul_reg;
  logic             abort_reg;
  logic             neg_q_reg;   // product sign for multiply, quotient sign for divide
  logic             neg_r_reg;   // remainder sign (dividend sign)
  logic [WIDTH:0]   acc_hi_reg;  // P_hi for multiply, 33-bit remainder R for divide
  logic [WIDTH-1:0] acc_lo_reg;  // P_lo for multiply, quotient Q for divide
  logic [WIDTH-1:0] opb_reg;     // |b|
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;
  logic             div_zero_reg;

  logic             valid_start;
  logic             is_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH:0]   div_hi_next;
  logic [WIDTH-1:0] div_lo_next;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign busy     = (state_reg != S_IDLE);
  assign done     = done_reg;
  assign div_zero = div_zero_reg;

  // Operand decode and one iteration of each datapath, plus the final sign fix-up.
  always_comb begin
    valid_start = start && ((op == OP_MUL) || (op == OP_DIV));
    is_signed   = !is_unsigned;
    a_mag       = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag       = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shift-add multiply: conditional add with carry, then shift the carry in.
    mul_sum     = {1'b0, acc_hi_reg[WIDTH-1:0]} +
                  (acc_lo_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
    mul_hi_next = {1'b0, mul_sum[WIDTH:1]};
    mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

    // Restoring divide: shift {R,Q} left, trial-subtract, keep if non-negative.
    div_shift   = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
    div_diff    = {1'b0, div_shift} - {2'b00, opb_reg};
    div_ok      = !div_diff[WIDTH+1];
    div_hi_next = div_ok ? div_diff[WIDTH:0] : div_shift;
    div_lo_next = {acc_lo_reg[WIDTH-2:0], div_ok};

    prod_raw    = {acc_hi_reg[WIDTH-1:0], acc_lo_reg};
    prod_fix    = neg_q_reg ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix     = neg_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
    rem_fix     = neg_r_reg ? (~acc_hi_reg[WIDTH-1:0] + 1'b1) : acc_hi_reg[WIDTH-1:0];
  end

  // Sequencer state, datapath registers and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      is_mul_reg   <= 1'b0;
      abort_reg    <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      opb_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (valid_start) begin
            is_mul_reg <= (op == OP_MUL);
            neg_q_reg  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_reg  <= is_signed && a[WIDTH-1];
            acc_hi_reg <= '0;
            acc_lo_reg <= a_mag;
            opb_reg    <= b_mag;
            cnt_reg    <= '0;
            if ((op == OP_DIV) && (b == '0)) begin
              abort_reg <= 1'b1;
              state_reg <= S_FIX;
            end else begin
              abort_reg <= 1'b0;
              state_reg <= S_CALC;
            end
          end else if (!start) begin
            // Moves to HI/LO only when no request is present at all.
            if (mthi) hi_reg <= a;
            if (mtlo) lo_reg <= a;
          end
        end
        S_CALC: begin
          if (is_mul_reg) begin
            acc_hi_reg <= mul_hi_next;
            acc_lo_reg <= mul_lo_next;
          end else begin
            acc_hi_reg <= div_hi_next;
            acc_lo_reg <= div_lo_next;
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          if (abort_reg) begin
            div_zero_reg <= 1'b1;
          end else if (is_mul_reg) begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end else begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end
          done_reg  <= 1'b1;
          abort_reg <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ula_muldiv_seq.md
# ula_muldiv_seq

Multi-cycle sequencer for the HI/LO multiply/divide operations. The ALU control decoder emits these as OP 4'b1100 (mult/multu) and OP 4'b1101 (div/divu). The block accepts an operation in one cycle, runs a 32-step iterative shift-add multiply or restoring divide, and writes the 64-bit result into internal HI/LO registers. It asserts `busy` so the pipeline control can stall dependent instructions, and it services mthi/mtlo writes while idle.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits; the step counter must hold values up to `WIDTH`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  4  ALU control code; 4'b1100 = multiply, 4'b1101 = divide; any other value with `start` is ignored.
- `is_unsigned`  in  1  1 = multu/divu (func[0]); 0 = signed.
- `a`, `b`  in  WIDTH  rs and rt operands, sampled with `start`.
- `mthi`, `mtlo`  in  1  write `a` into HI / LO.
- `hi`, `lo`  out  WIDTH  registered HI/LO contents.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a result (or a divide-by-zero abort) completes.
- `div_zero`  out  1  valid with `done`; 1 = divide with `b` == 0.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE + valid `start`:**
  - Latch operand magnitudes. In signed mode take |a| and |b|; in unsigned mode use raw values.
  - Latch the result sign: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31]. All forced to 0 when unsigned.
  - Clear the step counter and go to CALC.
  - Divide with `b` == 0: go directly to FIX with an abort flag set.
- **CALC, multiply:** 64-bit accumulator {P_hi, P_lo}, initialised {0, |a|}. Each step: if P_lo[0], P_hi += |b| with a 33-bit carry; then shift the whole accumulator right by 1 with the carry shifted in.
- **CALC, divide:** restoring divide. Remainder R (33 bits) starts at 0; quotient register Q starts at |a|. Each step: shift {R, Q} left by 1 and trial-subtract |b| from R. If the result is non-negative, keep it and set Q[0] = 1; otherwise restore R and set Q[0] = 0.
- After exactly WIDTH steps, CALC goes to FIX.
- **FIX:** apply two's-complement negation per the latched signs.
  - Multiply: HI:LO ← the 64-bit product.
  - Divide: LO ← quotient, HI ← remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Abort case: HI/LO unchanged and `div_zero` = 1.
  - Then return to IDLE.
- Signed -2^31 / -1 gives LO = 0x80000000, HI = 0. This is natural 32-bit wrap; no trap.
- `mthi` / `mtlo` act only in IDLE with `start` low; both may be asserted together. Ignored while busy. If asserted with `start`, `start` wins.
- `start` while busy is ignored; no queuing.

## Timing
- **Reset:** state IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, counter = 0. Reset mid-operation abandons the operation; HI/LO clear.
- **Normal operation:** `start` sampled at edge E0.
  - `busy` = 1 from E0 until E33: CALC for E1..E32, FIX at E33.
  - `hi`, `lo`, `done` = 1 and `busy` = 0 all become visible after E33.
  - Latency is 33 cycles; the next `start` is accepted at E34, i.e. in the `done` cycle.
- **Divide by zero:** `start` at E0, FIX at E1. `done` = 1 and `div_zero` = 1 after E1. `busy` is high for one cycle.
- `done` and `div_zero` are high for exactly one cycle and otherwise 0.
- `mthi` / `mtlo` at edge E: the new `hi` / `lo` value is visible after E.
- `hi` / `lo` hold their old values throughout CALC; there are no partial updates.

## Test plan
- Signed multiply, a = 7, b = -3 (0xFFFFFFFD) → after 33 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `done` pulses once; `busy` is high for exactly 33 cycles.
- Unsigned multiply, a = b = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. The same operands signed → HI = 0, LO = 1.
- Signed divide, a = -7, b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Unsigned divide by 0 after mthi(0x1234)/mtlo(0x5678) → `done` and `div_zero` both 1 one cycle after `start`; HI = 0x1234 and LO = 0x5678 unchanged.
- `start` (valid op) and `mthi` pulsed at cycle 5 of a running multiply → both ignored; the result matches the first operation only. `start` with op = 4'b0001 in IDLE → `busy` stays 0.
- `rst` asserted at cycle 10 of a divide → next cycle: state IDLE, HI = LO = 0, `busy` = 0, no `done`. A new multiply 2 × 3 then completes with LO = 6.
